// File: rtl/get_pixel_color_unit_pkg.sv
// Shared ray-tracer constants: float32 values, face-axis encodings, colour bundle.
package get_pixel_color_unit_pkg;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_AMBIENT = 32'h3E80_0000;  // 0.25
  localparam logic [30:0] FP_MAX_MAG = 31'h7F7F_FFFF;  // largest finite magnitude

  // Hit face axis; codes 3..7 fall through to the z component.
  typedef enum logic [2:0] {
    DIR_Z = 3'd0,
    DIR_X = 3'd1,
    DIR_Y = 3'd2
  } dir_e;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } rgb_t;

endpackage

// File: rtl/get_pixel_color_unit_fp_mul32.sv
// Two-stage float32 multiplier: truncating, flush-to-zero, saturating.
module fp_mul32
  import get_pixel_color_unit_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] p_out
);

  logic              sign_d, sign_q;
  logic              zero_d, zero_q;
  logic signed [9:0] exp_d, exp_q;
  logic [47:0]       mant_d, mant_q;
  logic [31:0]       p_d, p_q;

  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;

  // Stage A: sign, biased exponent sum and full 24x24 significand product.
  // A zero exponent on either side means zero or subnormal, both flushed.
  always_comb begin
    sign_d = a_in[31] ^ b_in[31];
    zero_d = (a_in[30:23] == 8'd0) || (b_in[30:23] == 8'd0);
    exp_d  = $signed({2'b00, a_in[30:23]}) + $signed({2'b00, b_in[30:23]}) - 10'sd127;
    mant_d = {24'd0, 1'b1, a_in[22:0]} * {24'd0, 1'b1, b_in[22:0]};
  end

  // Stage B: normalise by at most one place, drop the low bits (truncate),
  // then clamp underflow to signed zero and overflow to max finite.
  always_comb begin
    if (mant_q[47]) begin
      frac_n = mant_q[46:24];
      exp_n  = exp_q + 10'sd1;
    end else begin
      frac_n = mant_q[45:23];
      exp_n  = exp_q;
    end
    if (zero_q || exp_n <= 10'sd0)
      p_d = {sign_q, 31'd0};
    else if (exp_n >= 10'sd255)
      p_d = {sign_q, FP_MAX_MAG};
    else
      p_d = {sign_q, exp_n[7:0], frac_n};
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sign_q <= 1'b0;
      zero_q <= 1'b1;
      exp_q  <= '0;
      mant_q <= '0;
      p_q    <= '0;
    end else begin
      sign_q <= sign_d;
      zero_q <= zero_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      p_q    <= p_d;
    end
  end

  assign p_out = p_q;

endmodule

// File: rtl/get_pixel_color_unit.sv
// Shading back end: picks the hit-face cosine, floors it at AMBIENT,
// scales the material colour, or emits background on a miss. 4-cycle latency.
module get_pixel_color_unit
  import get_pixel_color_unit_pkg::*;
#(
  parameter logic [31:0] AMBIENT = FP_AMBIENT,
  parameter logic [31:0] BG_R    = FP_ZERO,
  parameter logic [31:0] BG_G    = FP_ZERO,
  parameter logic [31:0] BG_B    = FP_ZERO
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] ray_x,
  input  logic [31:0] ray_y,
  input  logic [31:0] ray_z,
  input  logic [31:0] t_in,
  input  logic [31:0] block_pos_x,
  input  logic [31:0] block_pos_y,
  input  logic [31:0] block_pos_z,
  input  logic [31:0] block_mat_x,
  input  logic [31:0] block_mat_y,
  input  logic [31:0] block_mat_z,
  input  logic [2:0]  block_dir,
  output logic [31:0] r_out,
  output logic [31:0] g_out,
  output logic [31:0] b_out,
  output logic        rgb_valid
);

  localparam int STAGES = 3;

  // Valid bits: [0] input regs, [1] shade regs, [2] mul stage A, [3] mul stage B.
  logic [STAGES:0] vld_pipe_d, vld_pipe_q;
  // Miss flag follows the sample from the shade regs through both mul stages.
  logic [2:0]      miss_pipe_d, miss_pipe_q;

  // Stage 1 registers
  logic [31:0] ray_x_d, ray_x_q, ray_y_d, ray_y_q, ray_z_d, ray_z_q;
  logic [8:0]  t_se_d, t_se_q;         // sign and exponent of t
  rgb_t        mat1_d, mat1_q;
  logic [2:0]  dir_d, dir_q;

  // Stage 2 registers
  logic [31:0] shade_d, shade_q;
  rgb_t        mat2_d, mat2_q;

  // Output registers
  rgb_t        rgb_d, rgb_q;
  logic        rgb_valid_d, rgb_valid_q;

  logic [31:0] ray_sel;
  logic [30:0] cos_mag;
  rgb_t        prod;

  // Block position is carried for future use; the t mantissa only matters
  // for NaN vs Inf, which both count as a miss.
  logic unused_bits;
  assign unused_bits = ^{block_pos_x, block_pos_y, block_pos_z, t_in[22:0], ray_sel[31]};

  // Next-state for every pipeline stage and the output register.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], valid_in};

    ray_x_d = ray_x;
    ray_y_d = ray_y;
    ray_z_d = ray_z;
    t_se_d  = t_in[31:23];
    mat1_d  = '{r: block_mat_x, g: block_mat_y, b: block_mat_z};
    dir_d   = block_dir;

    case (dir_e'(dir_q))
      DIR_X:   ray_sel = ray_x_q;
      DIR_Y:   ray_sel = ray_y_q;
      default: ray_sel = ray_z_q;
    endcase
    // Both operands are non-negative, so integer compare orders them as floats.
    cos_mag = (ray_sel[30:0] > AMBIENT[30:0]) ? ray_sel[30:0] : AMBIENT[30:0];
    shade_d = {1'b0, cos_mag};
    mat2_d  = mat1_q;
    // Inf/NaN or any negative t (including -0) is a miss; +0 is a hit.
    miss_pipe_d = {miss_pipe_q[1:0], (t_se_q[7:0] == 8'hFF) || t_se_q[8]};

    rgb_valid_d = vld_pipe_q[STAGES];
    rgb_d       = rgb_q;
    if (vld_pipe_q[STAGES])
      rgb_d = miss_pipe_q[2] ? '{r: BG_R, g: BG_G, b: BG_B} : prod;
  end

  // All pipeline state, cleared asynchronously so in-flight samples are dropped.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_pipe_q  <= '0;
      miss_pipe_q <= '0;
      ray_x_q     <= '0;
      ray_y_q     <= '0;
      ray_z_q     <= '0;
      t_se_q      <= '0;
      mat1_q      <= '0;
      dir_q       <= '0;
      shade_q     <= '0;
      mat2_q      <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      miss_pipe_q <= miss_pipe_d;
      ray_x_q     <= ray_x_d;
      ray_y_q     <= ray_y_d;
      ray_z_q     <= ray_z_d;
      t_se_q      <= t_se_d;
      mat1_q      <= mat1_d;
      dir_q       <= dir_d;
      shade_q     <= shade_d;
      mat2_q      <= mat2_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  fp_mul32 u_mul_r (.clk_in(clk_in), .rst_in(rst_in), .a_in(mat2_q.r), .b_in(shade_q), .p_out(prod.r));
  fp_mul32 u_mul_g (.clk_in(clk_in), .rst_in(rst_in), .a_in(mat2_q.g), .b_in(shade_q), .p_out(prod.g));
  fp_mul32 u_mul_b (.clk_in(clk_in), .rst_in(rst_in), .a_in(mat2_q.b), .b_in(shade_q), .p_out(prod.b));

  assign r_out     = rgb_q.r;
  assign g_out     = rgb_q.g;
  assign b_out     = rgb_q.b;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_get_pixel_color_unit.sv
// Directed bench for get_pixel_color_unit with hand-computed float32 results.
module tb_get_pixel_color_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] ray_x = '0, ray_y = '0, ray_z = '0, t_in = '0;
  logic [31:0] block_pos_x = '0, block_pos_y = '0, block_pos_z = '0;
  logic [31:0] block_mat_x = '0, block_mat_y = '0, block_mat_z = '0;
  logic [2:0]  block_dir = '0;
  logic [31:0] r_out, g_out, b_out;
  logic        rgb_valid;

  get_pixel_color_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .ray_x(ray_x), .ray_y(ray_y), .ray_z(ray_z), .t_in(t_in),
    .block_pos_x(block_pos_x), .block_pos_y(block_pos_y), .block_pos_z(block_pos_z),
    .block_mat_x(block_mat_x), .block_mat_y(block_mat_y), .block_mat_z(block_mat_z),
    .block_dir(block_dir),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .rgb_valid(rgb_valid)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [31:0] r, g, b;
  } ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Record every output pulse with the cycle it appeared in.
  always @(negedge clk_in) if (rgb_valid === 1'b1) got_q.push_back('{cyc, r_out, g_out, b_out});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Present one sample for the next edge; expect it 4 edges after that one.
  task automatic issue(input logic [31:0] rx, ry, rz, t, mr, mg, mb, input logic [2:0] dir,
                       input logic [31:0] er, eg, eb, input bit expect_out);
    ray_x = rx; ray_y = ry; ray_z = rz; t_in = t;
    block_mat_x = mr; block_mat_y = mg; block_mat_z = mb; block_dir = dir;
    block_pos_x = $urandom; block_pos_y = $urandom; block_pos_z = $urandom;
    valid_in = 1'b1;
    if (expect_out) exp_q.push_back('{cyc + 5, er, eg, eb});
    step();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    ray_x = $urandom; ray_y = $urandom; ray_z = $urandom; t_in = $urandom;
    repeat (n) step();
  endtask

  localparam logic [31:0] ONE = 32'h3F80_0000, HALF = 32'h3F00_0000, QTR = 32'h3E80_0000;
  localparam logic [31:0] SML = 32'h3727_C5AC, THIT = 32'h4496_0000;

  initial begin
    // Reset held with live inputs: nothing may leak out.
    for (int i = 0; i < 10; i++) begin
      ray_x = $urandom; ray_y = $urandom; ray_z = $urandom; t_in = $urandom;
      block_mat_x = $urandom; block_mat_y = $urandom; block_mat_z = $urandom;
      block_dir = 3'($urandom); valid_in = 1'b1;
      step();
      chk("rst_valid", 64'(rgb_valid), 64'd0);
      chk("rst_rgb", {r_out | g_out | b_out}, 64'd0);
    end

    // Release reset together with the first valid sample.
    rst_in = 1'b1;
    // Ambient floor, then cosine pass-through back-to-back.
    issue(SML, SML, 32'h3F80_0054, THIT, ONE, 0, 0, 3'd1, QTR, 0, 0, 1);
    issue(SML, SML, 32'h3F7F_EC2F, THIT, ONE, 0, 0, 3'd0, 32'h3F7F_EC2F, 0, 0, 1);
    idle(8);
    chk("hold_valid", 64'(rgb_valid), 64'd0);
    chk("hold_r", 64'(r_out), 64'h3F7F_EC2F);

    // Mid-grey on the y face with a negative component.
    issue(SML, 32'hBF00_0000, SML, ONE, HALF, HALF, HALF, 3'd2, QTR, QTR, QTR, 1);
    // Misses: +Inf, negative, -0; then +0 is a hit.
    issue(SML, 32'hBF00_0000, SML, 32'h7F80_0000, HALF, HALF, HALF, 3'd2, 0, 0, 0, 1);
    issue(SML, 32'hBF00_0000, SML, 32'hBF80_0000, HALF, HALF, HALF, 3'd2, 0, 0, 0, 1);
    issue(SML, 32'hBF00_0000, SML, 32'h8000_0000, HALF, HALF, HALF, 3'd2, 0, 0, 0, 1);
    issue(SML, 32'hBF00_0000, SML, 32'h0000_0000, HALF, HALF, HALF, 3'd2, QTR, QTR, QTR, 1);
    // Code 5 selects z; repeated with different block_pos.
    issue(ONE, 0, 32'h3F40_0000, THIT, ONE, HALF, 0, 3'd5, 32'h3F40_0000, 32'h3EC0_0000, 0, 1);
    issue(ONE, 0, 32'h3F40_0000, THIT, ONE, HALF, 0, 3'd5, 32'h3F40_0000, 32'h3EC0_0000, 0, 1);
    // Truncation (RNE would give 0x3F200000) and subnormal input flush.
    issue(32'h3F40_0000, 0, 0, THIT, 32'h3F55_5555, 32'h3F7F_FFFF, 32'h0040_0000, 3'd1,
          32'h3F1F_FFFF, 32'h3F3F_FFFF, 0, 1);
    // Result underflow flushes to zero.
    issue(32'h3F40_0000, 0, 0, THIT, 32'h0080_0000, 32'h8000_0000, ONE, 3'd1,
          0, 32'h8000_0000, 32'h3F40_0000, 1);
    idle(8);

    // Reset pulse while three samples are in flight: all are dropped.
    issue(0, 0, ONE, THIT, ONE, ONE, ONE, 3'd0, 0, 0, 0, 0);
    issue(0, 0, ONE, THIT, ONE, ONE, ONE, 3'd0, 0, 0, 0, 0);
    issue(0, 0, ONE, THIT, ONE, ONE, ONE, 3'd0, 0, 0, 0, 0);
    valid_in = 1'b0;
    rst_in = 1'b0;
    step();
    chk("midrst_valid", 64'(rgb_valid), 64'd0);
    chk("midrst_rgb", {r_out | g_out | b_out}, 64'd0);
    rst_in = 1'b1;
    idle(10);
    chk("post_rst_valid", 64'(rgb_valid), 64'd0);

    // Every recorded pulse must match the expected stream, cycle for cycle.
    chk("num_outputs", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("out%0d_cyc", i), 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
      chk($sformatf("out%0d_r", i), 64'(got_q[i].r), 64'(exp_q[i].r));
      chk($sformatf("out%0d_g", i), 64'(got_q[i].g), 64'(exp_q[i].g));
      chk($sformatf("out%0d_b", i), 64'(got_q[i].b), 64'(exp_q[i].b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
